// File: rtl/frame_sched.sv
// frame_sched: fills the back bank of a double-buffered LED cube frame RAM
// from either the pattern generator (mode 00) or the UART (mode 11), and
// swaps banks only at the end of a full scan. Modes 01/10 freeze the display.
// Optional build macro FRAME_SCHED_RESYNC_EN: a UART inter-byte gap of
// RESYNC_CYCLES clocks aborts a partially received frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | freeze mode (01/10), or first cycle after reset release
// FILL      | accepting bytes into bank ~disp_bank
// WAIT_SWAP | back bank complete, waiting for scan_done to swap banks
module frame_sched #(
  parameter int FRAME_BYTES   = 64,
  parameter int RESYNC_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        gen_req,
  input  logic        gen_valid,
  input  logic [7:0]  gen_data,
  input  logic        scan_done,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        disp_bank,
  output logic [15:0] frame_cnt,
  output logic        overrun
);

  // The write address carries a 6-bit byte index, so frames are capped at 64.
  if (FRAME_BYTES < 2 || FRAME_BYTES > 64) begin : g_bad_frame
    $error("frame_sched: FRAME_BYTES must be in 2..64");
  end
  if (RESYNC_CYCLES < 1) begin : g_bad_resync
    $error("frame_sched: RESYNC_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} state_t;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

  state_t     state, state_nxt;
  logic [1:0] mode_q;
  logic [5:0] idx, idx_nxt;
  logic       mode_chg, run_mode;
  logic       accept, swap, drop;
  logic [7:0] acc_data;
  logic       resync_hit;

  assign mode_chg = (mode != mode_q);
  assign run_mode = (mode == 2'b00) || (mode == 2'b11);

`ifdef FRAME_SCHED_RESYNC_EN
  localparam int GW = $clog2(RESYNC_CYCLES + 1);
  logic [GW-1:0] gap_cnt;
  logic          gap_run;

  // Counts idle UART cycles only while a partial frame is in progress;
  // rx_valid stands in for acceptance since FILL + mode 11 accepts every strobe.
  assign gap_run    = (state == FILL) && (mode == 2'b11) && !mode_chg &&
                      (idx != 6'd0) && !rx_valid;
  assign resync_hit = gap_run && (gap_cnt == GW'(RESYNC_CYCLES));

  // Gap counter: clears on any byte or whenever no partial frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         gap_cnt <= '0;
    else if (gap_run && !resync_hit) gap_cnt <= gap_cnt + GW'(1);
    else                             gap_cnt <= '0;
  end
`else
  assign resync_hit = 1'b0;
`endif

  // State, index and mode history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 6'd0;
      mode_q <= 2'b00;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      mode_q <= mode;
    end
  end

  // Next state, byte acceptance and swap/drop decisions. A mode change
  // blocks acceptance for its cycle so the aborted frame gets no more writes.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gen_req   = 1'b0;
    accept    = 1'b0;
    acc_data  = rx_data;
    swap      = 1'b0;
    drop      = 1'b0;
    if (mode_chg) begin
      idx_nxt   = 6'd0;
      state_nxt = run_mode ? FILL : IDLE;
    end else begin
      case (state)
        IDLE: begin
          drop = (mode == 2'b11) && rx_valid;
          if (run_mode) state_nxt = FILL;
        end
        FILL: begin
          gen_req = (mode == 2'b00);
          if (mode == 2'b11) begin
            accept   = rx_valid;
            acc_data = rx_data;
          end else if (mode == 2'b00) begin
            accept   = gen_valid;
            acc_data = gen_data;
          end
          if (accept) begin
            if (idx == LAST_IDX) begin
              idx_nxt   = 6'd0;
              state_nxt = WAIT_SWAP;
            end else begin
              idx_nxt = idx + 6'd1;
            end
          end else if (resync_hit) begin
            idx_nxt = 6'd0;
          end
        end
        WAIT_SWAP: begin
          drop = (mode == 2'b11) && rx_valid;
          if (scan_done) begin
            swap      = 1'b1;
            state_nxt = FILL;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered RAM write port, bank selection, swap counter and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= 7'd0;
      wr_data   <= 8'd0;
      disp_bank <= 1'b0;
      frame_cnt <= 16'd0;
      overrun   <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= {~disp_bank, idx};
        wr_data <= acc_data;
      end
      if (swap) begin
        disp_bank <= ~disp_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: expected RAM writes are queued as
// bytes are driven and compared as wr_en appears.
module tb_frame_sched;
  localparam int RESYNC = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        gen_req;
  logic        gen_valid = 1'b0;
  logic [7:0]  gen_data = 8'd0;
  logic        scan_done = 1'b0;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        disp_bank;
  logic [15:0] frame_cnt;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  logic [14:0] mon_e;

  logic       exp_fill;
  logic [5:0] exp_idx;
  logic       exp_bank;
  int         exp_cnt;
  logic       exp_ovr;
  logic       saved_bank;

  frame_sched #(.FRAME_BYTES(64), .RESYNC_CYCLES(RESYNC)) dut (
    .clk(clk), .rst(rst), .mode(mode), .rx_valid(rx_valid), .rx_data(rx_data),
    .gen_req(gen_req), .gen_valid(gen_valid), .gen_data(gen_data),
    .scan_done(scan_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank), .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every wr_en must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      check("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e[14:8]);
        check("wr_data", wr_data, mon_e[7:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_init();
    exp_fill = (mode == 2'b00) || (mode == 2'b11);
    exp_idx  = 6'd0;
    exp_bank = 1'b0;
    exp_cnt  = 0;
    exp_ovr  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    exp_q.delete();
    rst = 1'b0;
    model_init();
    tick(3);
  endtask

  // One-cycle byte strobe from UART (is_rx) or generator, optionally with scan_done.
  task automatic send(input bit is_rx, input logic [7:0] d, input bit with_scan);
    logic f0, acc;
    f0 = exp_fill;
    if (is_rx) begin rx_valid = 1'b1; rx_data = d; end
    else begin gen_valid = 1'b1; gen_data = d; end
    scan_done = with_scan;
    acc = f0 && (is_rx ? (mode == 2'b11) : (mode == 2'b00));
    if (is_rx && mode == 2'b11 && !f0) exp_ovr = 1'b1;
    if (with_scan && !f0) begin
      exp_bank = ~exp_bank;
      exp_cnt++;
      exp_fill = 1'b1;
    end
    if (acc) begin
      exp_q.push_back({~exp_bank, exp_idx, d});
      if (exp_idx == 6'd63) begin exp_idx = 6'd0; exp_fill = 1'b0; end
      else exp_idx = exp_idx + 6'd1;
    end
    tick(1);
    rx_valid = 1'b0; gen_valid = 1'b0; scan_done = 1'b0;
  endtask

  task automatic pulse_scan();
    scan_done = 1'b1;
    if (!exp_fill) begin
      exp_bank = ~exp_bank;
      exp_cnt++;
      exp_fill = 1'b1;
    end
    tick(1);
    scan_done = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    if (m != mode) begin
      exp_idx  = 6'd0;
      exp_fill = (m == 2'b00) || (m == 2'b11);
    end
    mode = m;
    tick(1);
  endtask

  task automatic gap(input int n);
`ifdef FRAME_SCHED_RESYNC_EN
    if (exp_fill && mode == 2'b11 && exp_idx != 6'd0 && n > RESYNC) exp_idx = 6'd0;
`endif
    tick(n);
  endtask

  task automatic check_outs();
    check("disp_bank", disp_bank, exp_bank);
    check("frame_cnt", frame_cnt, exp_cnt);
    check("overrun", overrun, exp_ovr);
  endtask

  task automatic check_reset_vals();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_gen_req", gen_req, 0);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overrun", overrun, 0);
  endtask

  initial begin
    int n;
    tick(2);
    check_reset_vals();

    // Generator frame in mode 00
    rst = 1'b0;
    model_init();
    n = 0;
    while (!gen_req && n < 10) begin tick(1); n++; end
    check("gen_req_rise", gen_req, 1);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) send(1'b1, 8'hAA, 1'b0);
      if (i == 32) pulse_scan();
      check("gen_req_fill", gen_req, 1);
      send(1'b0, 8'(i), 1'b0);
    end
    check("gen_req_drop", gen_req, 0);
    send(1'b0, 8'h55, 1'b0);
    check("gen_bank_hold", disp_bank, 0);
    tick(100);
    pulse_scan();
    check("gen_bank_swap", disp_bank, 1);
    check("gen_frame_cnt", frame_cnt, 1);
    check_outs();
    check("gen_req_again", gen_req, 1);
    check("gen_q_empty", exp_q.size(), 0);

    // Ten UART frames, alternating banks
    mode = 2'b11;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 64; i++) send(1'b1, 8'(f) ^ 8'(i), 1'b0);
      check("uart_bank_pre", disp_bank, exp_bank);
      pulse_scan();
      check_outs();
    end
    check("uart_frame_cnt10", frame_cnt, 10);
    check("uart_overrun0", overrun, 0);
    check("uart_bank_final", disp_bank, 0);

    // Inter-byte gap behaviour
    for (int i = 0; i < 20; i++) send(1'b1, 8'h40 | 8'(i), 1'b0);
    gap(RESYNC + 10);
    for (int i = 0; i < 44; i++) send(1'b1, 8'h80 | 8'(i), 1'b0);
    pulse_scan();
`ifdef FRAME_SCHED_RESYNC_EN
    check("gap_cnt_44", frame_cnt, 10);
`else
    check("gap_cnt_44", frame_cnt, 11);
`endif
    for (int i = 44; i < 64; i++) send(1'b1, 8'h80 | 8'(i), 1'b0);
    pulse_scan();
    check("gap_cnt_64", frame_cnt, 11);
    check_outs();
    check("gap_q_empty", exp_q.size(), 0);

    // Last byte coincides with scan_done
    do_reset();
    for (int i = 0; i < 63; i++) send(1'b1, 8'(i) ^ 8'h3C, 1'b0);
    send(1'b1, 8'hEE, 1'b1);
    check("same_cyc_cnt", frame_cnt, 0);
    check("same_cyc_bank", disp_bank, 0);
    pulse_scan();
    check("next_scan_bank", disp_bank, 1);
    check("next_scan_cnt", frame_cnt, 1);

    // 65th byte before scan_done is dropped
    for (int i = 0; i < 64; i++) send(1'b1, 8'hC0 ^ 8'(i), 1'b0);
    check("ovr_pre", overrun, 0);
    send(1'b1, 8'h99, 1'b0);
    tick(2);
    check("ovr_set", overrun, 1);
    pulse_scan();
    check_outs();
    check("ovr_q_empty", exp_q.size(), 0);

    // Mode switch 11->01 mid-frame, then asynchronous reset mid-frame
    for (int i = 0; i < 30; i++) send(1'b1, 8'h11 + 8'(i), 1'b0);
    saved_bank = disp_bank;
    set_mode(2'b01);
    for (int i = 0; i < 3; i++) send(1'b1, 8'hF0 + 8'(i), 1'b0);
    tick(5);
    check("freeze_bank", disp_bank, saved_bank);
    check("freeze_q_empty", exp_q.size(), 0);
    check_outs();
    set_mode(2'b11);
    for (int i = 0; i < 10; i++) send(1'b1, 8'h20 + 8'(i), 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    rx_valid = 1'b0;
    tick(2);
    exp_q.delete();
    rst = 1'b0;
    model_init();
    tick(4);
    check("post_rst_wr_en", wr_en, 0);
    check_outs();
    check("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
